// File: rtl/run_detect.sv
// Serial run-length detector: flags runs of RUN_LEN equal bits of a mode-selected
// polarity, either sustained while the run lasts or restarting after each hit.
module run_detect #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 4,
    parameter int HIT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in,
    input  logic [1:0]       mode,
    input  logic             overlap,
    input  logic             clr,
    output logic             out,
    output logic             out_pol,
    output logic [CNT_W-1:0] run_cnt,
    output logic [HIT_W-1:0] hit_cnt
);

    typedef enum logic {
        EMPTY,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);

    state_t             state_q, state_d;
    logic               last_bit_q, last_bit_d;
    logic [CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [HIT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic               out_q, out_d;
    logic               out_pol_q, out_pol_d;

    logic [CNT_W-1:0]   new_cnt;
    logic               pol_en;
    logic               hit;

    always_comb begin
        state_d    = state_q;
        last_bit_d = last_bit_q;
        run_cnt_d  = run_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        out_d      = 1'b0;
        out_pol_d  = out_pol_q;
        new_cnt    = run_cnt_q;
        pol_en     = 1'b0;
        hit        = 1'b0;

        if (clr) begin
            state_d    = EMPTY;
            last_bit_d = 1'b0;
            run_cnt_d  = '0;
            hit_cnt_d  = '0;
            out_pol_d  = 1'b0;
        end else if (in_valid) begin
            if (state_q == EMPTY || in != last_bit_q) begin
                new_cnt = CNT_W'(1);
            end else if (run_cnt_q != CNT_MAX) begin
                new_cnt = run_cnt_q + CNT_W'(1);
            end

            // mode[0] enables runs of 1s, mode[1] enables runs of 0s
            pol_en = in ? mode[0] : mode[1];

            if (overlap) begin
                hit       = pol_en && (new_cnt >= RUN_LEN_C);
                run_cnt_d = new_cnt;
            end else begin
                hit       = pol_en && (new_cnt == RUN_LEN_C);
                run_cnt_d = hit ? '0 : new_cnt;
            end

            state_d    = RUN;
            last_bit_d = in;

            if (hit) begin
                out_d     = 1'b1;
                out_pol_d = in;
                hit_cnt_d = hit_cnt_q + HIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= EMPTY;
            last_bit_q <= 1'b0;
            run_cnt_q  <= '0;
            hit_cnt_q  <= '0;
            out_q      <= 1'b0;
            out_pol_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_bit_q <= last_bit_d;
            run_cnt_q  <= run_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            out_q      <= out_d;
            out_pol_q  <= out_pol_d;
        end
    end

    assign out     = out_q;
    assign out_pol = out_pol_q;
    assign run_cnt = run_cnt_q;
    assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_run_detect.sv
// Directed self-checking bench for run_detect with hand-computed expectations;
// a second instance with a 3-bit run counter covers counter saturation.
module tb_run_detect;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_bit;
    logic [1:0] mode;
    logic       overlap;
    logic       clr;

    logic       out;
    logic       out_pol;
    logic [3:0] run_cnt;
    logic [7:0] hit_cnt;

    logic       out3;
    logic       out_pol3;
    logic [2:0] run_cnt3;
    logic [7:0] hit_cnt3;

    int checks;
    int errors;

    run_detect #(.RUN_LEN(4), .CNT_W(4), .HIT_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in       (in_bit),
        .mode     (mode),
        .overlap  (overlap),
        .clr      (clr),
        .out      (out),
        .out_pol  (out_pol),
        .run_cnt  (run_cnt),
        .hit_cnt  (hit_cnt)
    );

    run_detect #(.RUN_LEN(4), .CNT_W(3), .HIT_W(8)) dut3 (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in       (in_bit),
        .mode     (mode),
        .overlap  (overlap),
        .clr      (clr),
        .out      (out3),
        .out_pol  (out_pol3),
        .run_cnt  (run_cnt3),
        .hit_cnt  (hit_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Drives one cycle of input and returns 1 time unit after the capturing edge
    task automatic applyStimulus(input logic v, input logic b);
        in_valid = v;
        in_bit   = b;
        @(posedge clk);
        #1;
    endtask

    task automatic clearAll();
        clr = 1'b1;
        applyStimulus(1'b1, 1'b1);
        clr = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        mode     = 2'b11;
        overlap  = 1'b1;
        clr      = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out", out, 0);
        checkOutput("reset_out_pol", out_pol, 0);
        checkOutput("reset_run_cnt", run_cnt, 0);
        checkOutput("reset_hit_cnt", hit_cnt, 0);
        #2 reset = 1'b1;

        // Sustained detection on a run of 1s, then a polarity change
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("ovl_out_%0d", i + 1), out, (i >= 3) ? 1 : 0);
            checkOutput($sformatf("ovl_run_%0d", i + 1), run_cnt, i + 1);
        end
        applyStimulus(1'b1, 1'b0);
        checkOutput("ovl_out_after0", out, 0);
        checkOutput("ovl_run_after0", run_cnt, 1);
        checkOutput("ovl_hit", hit_cnt, 2);
        checkOutput("ovl_pol", out_pol, 1);

        // Clear overrides a simultaneous sample
        clearAll();
        checkOutput("clr_run", run_cnt, 0);
        checkOutput("clr_hit", hit_cnt, 0);
        checkOutput("clr_out", out, 0);
        checkOutput("clr_pol", out_pol, 0);

        // Restart mode: eight 1s give pulses after the 4th and 8th only
        overlap = 1'b0;
        mode    = 2'b01;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("rst_out_%0d", i + 1), out, (i == 3 || i == 7) ? 1 : 0);
            checkOutput($sformatf("rst_run_%0d", i + 1), run_cnt, (i + 1) % 4);
        end
        checkOutput("rst_pol", out_pol, 1);
        checkOutput("rst_hit", hit_cnt, 2);

        // Disabled polarity still counts but never fires
        clearAll();
        overlap = 1'b1;
        mode    = 2'b01;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("dis_out0_%0d", i + 1), out, 0);
        end
        checkOutput("dis_run0", run_cnt, 4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("dis_out1_%0d", i + 1), out, (i == 3) ? 1 : 0);
        end
        checkOutput("dis_pol1", out_pol, 1);
        checkOutput("dis_hit1", hit_cnt, 1);
        mode = 2'b10;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("zero_out_%0d", i + 1), out, (i == 3) ? 1 : 0);
        end
        checkOutput("zero_pol", out_pol, 0);
        checkOutput("zero_hit", hit_cnt, 2);

        // Invalid cycles hold the run and drop out
        clearAll();
        mode = 2'b11;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("gap_run_%0d", i), run_cnt, 2);
            checkOutput($sformatf("gap_out_%0d", i), out, 0);
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("gap_out_3rd", out, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("gap_out_4th", out, 1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("gap_out_idle", out, 0);
        checkOutput("gap_run_idle", run_cnt, 4);

        // Saturation of the 3-bit counter under a long run
        clearAll();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("sat_run3_%0d", i + 1), run_cnt3, (i + 1 > 7) ? 7 : i + 1);
            checkOutput($sformatf("sat_out3_%0d", i + 1), out3, (i >= 3) ? 1 : 0);
        end
        checkOutput("sat_run4", run_cnt, 10);
        checkOutput("sat_hit", hit_cnt, 7);

        // Asynchronous reset mid-run
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1);
        checkOutput("pre_rst_hit", hit_cnt, 10);
        checkOutput("pre_rst_out", out, 1);
        #2 reset = 1'b0;
        #1;
        checkOutput("async_out", out, 0);
        checkOutput("async_pol", out_pol, 0);
        checkOutput("async_run", run_cnt, 0);
        checkOutput("async_hit", hit_cnt, 0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("held_run", run_cnt, 0);
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("post_run_%0d", i + 1), run_cnt, i + 1);
            checkOutput($sformatf("post_out_%0d", i + 1), out, (i == 3) ? 1 : 0);
        end
        checkOutput("post_hit", hit_cnt, 1);

        in_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
